// File: rtl/ddc_ctrl_pkg.sv
// Shared types and helpers for the DDC retune sequencer and its rbus byte writer.
package ddc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    CLEAR,
    FLUSH,
    DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } wr_phase_t;

  localparam int MASK_FREQ  = 0;
  localparam int MASK_DECIM = 1;

  localparam logic [2:0] FREQ_BYTES  = 3'd4;
  localparam logic [2:0] DECIM_BYTES = 3'd2;

  // Byte pointer 0..3 walks the frequency word, 4..5 the decimation rate.
  function automatic logic [7:0] byte_data(input logic [2:0]  ptr,
                                           input logic [31:0] freq,
                                           input logic [12:0] decim);
    logic [7:0] b;
    case (ptr)
      3'd0:    b = freq[7:0];
      3'd1:    b = freq[15:8];
      3'd2:    b = freq[23:16];
      3'd3:    b = freq[31:24];
      3'd4:    b = decim[7:0];
      3'd5:    b = {3'b000, decim[12:8]};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] first_byte(input logic [1:0] mask);
    return mask[MASK_FREQ] ? 3'd0 : FREQ_BYTES;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rbus_byte_writer.sv
// Three-phase rbus single-byte write engine: setup, strobe, hold.
// A start accepted during hold chains straight into the next byte's setup.
module rbus_byte_writer
  import ddc_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       ready,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_data,
  output logic       bus_we,
  output logic       bus_strobe
);

  wr_phase_t  phase_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       we_q;
  logic       strobe_q;

  assign ready      = (phase_q == PH_IDLE) || (phase_q == PH_HOLD);
  assign bus_addr   = addr_q;
  assign bus_data   = data_q;
  assign bus_we     = we_q;
  assign bus_strobe = strobe_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= PH_IDLE;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      we_q     <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      case (phase_q)
        PH_SETUP: begin
          phase_q  <= PH_STROBE;
          strobe_q <= 1'b1;
        end
        PH_STROBE: begin
          phase_q  <= PH_HOLD;
          strobe_q <= 1'b0;
        end
        default: begin
          if (start) begin
            phase_q  <= PH_SETUP;
            addr_q   <= addr;
            data_q   <= data;
            we_q     <= 1'b1;
            strobe_q <= 1'b0;
          end else begin
            phase_q  <= PH_IDLE;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            we_q     <= 1'b0;
            strobe_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ddc_retune_sequencer.sv
// Retune sequencer for the DDC chain: rbus register writes, bypass flags,
// aclr pulse, then blanking of the first FLUSH_SAMPLES output strobes.
module ddc_retune_sequencer
  import ddc_ctrl_pkg::*;
#(
  parameter logic [7:0] IF_FREQ_ADDR    = 8'd0,
  parameter logic [7:0] DECIM_RATE_ADDR = 8'd1,
  parameter int         CLEAR_CYCLES    = 4,
  parameter int         FLUSH_SAMPLES   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_freq,
  input  logic [12:0] req_decim,
  input  logic [1:0]  req_mask,
  input  logic [3:0]  req_cfgflags,
  output logic        busy,
  output logic        done,
  output logic        ddc_enable,
  output logic        ddc_aclr,
  output logic [3:0]  ddc_cfgflags,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_data,
  output logic        bus_we,
  output logic        bus_strobe,
  input  logic        ddc_strobe_in,
  output logic        iq_valid
);

  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_SAMPLES - 1);
  localparam logic [2:0] LAST_BYTE  = FREQ_BYTES + DECIM_BYTES - 3'd1;

  seq_state_t  state_q;
  logic [31:0] freq_q;
  logic [12:0] decim_q;
  logic [1:0]  mask_q;
  logic [3:0]  cfg_q;
  logic [2:0]  ptr_q;
  logic [7:0]  cnt_q;
  logic        req_ready_q;
  logic        busy_q;
  logic        done_q;
  logic        enable_q;
  logic        aclr_q;
  logic [3:0]  ddc_cfg_q;

  logic        accept;
  logic        has_next;
  logic [2:0]  ptr_nxt;
  logic        wr_start;
  logic        wr_ready;
  logic [2:0]  wr_ptr;
  logic [31:0] wr_freq;
  logic [12:0] wr_decim;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;

  assign accept       = req_valid && req_ready_q;
  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ddc_enable   = enable_q;
  assign ddc_aclr     = aclr_q;
  assign ddc_cfgflags = ddc_cfg_q;
  assign iq_valid     = (state_q == FLUSH) ? 1'b0 : ddc_strobe_in;

  always_comb begin
    has_next = 1'b0;
    ptr_nxt  = ptr_q;
    if (ptr_q == FREQ_BYTES - 3'd1) begin
      has_next = mask_q[MASK_DECIM];
      ptr_nxt  = FREQ_BYTES;
    end else if (ptr_q != LAST_BYTE) begin
      has_next = 1'b1;
      ptr_nxt  = ptr_q + 3'd1;
    end
  end

  // The first byte is launched from the live request so its setup cycle
  // coincides with the shadow capture; later bytes come from the shadows.
  always_comb begin
    wr_start = 1'b0;
    wr_ptr   = ptr_nxt;
    wr_freq  = freq_q;
    wr_decim = decim_q;
    if (state_q == IDLE) begin
      wr_start = accept && (req_mask != 2'b00);
      wr_ptr   = first_byte(req_mask);
      wr_freq  = req_freq;
      wr_decim = req_decim;
    end else if (state_q == WR_HOLD) begin
      wr_start = wr_ready && has_next;
    end
    wr_addr = (wr_ptr < FREQ_BYTES) ? IF_FREQ_ADDR : DECIM_RATE_ADDR;
    wr_data = byte_data(wr_ptr, wr_freq, wr_decim);
  end

  rbus_byte_writer u_writer (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (wr_start),
    .addr       (wr_addr),
    .data       (wr_data),
    .ready      (wr_ready),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_we     (bus_we),
    .bus_strobe (bus_strobe)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      freq_q      <= 32'h0;
      decim_q     <= 13'h0;
      mask_q      <= 2'b00;
      cfg_q       <= 4'h0;
      ptr_q       <= 3'd0;
      cnt_q       <= 8'h00;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      enable_q    <= 1'b1;
      aclr_q      <= 1'b0;
      ddc_cfg_q   <= 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            freq_q      <= req_freq;
            decim_q     <= req_decim;
            mask_q      <= req_mask;
            cfg_q       <= req_cfgflags;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_mask == 2'b00) begin
              state_q   <= CLEAR;
              cnt_q     <= 8'h00;
              aclr_q    <= 1'b1;
              enable_q  <= 1'b0;
              ddc_cfg_q <= req_cfgflags;
            end else begin
              state_q <= WR_SETUP;
              ptr_q   <= first_byte(req_mask);
            end
          end
        end
        WR_SETUP:  state_q <= WR_STROBE;
        WR_STROBE: state_q <= WR_HOLD;
        WR_HOLD: begin
          if (wr_start) begin
            state_q <= WR_SETUP;
            ptr_q   <= ptr_nxt;
          end else begin
            state_q   <= CLEAR;
            cnt_q     <= 8'h00;
            aclr_q    <= 1'b1;
            enable_q  <= 1'b0;
            ddc_cfg_q <= cfg_q;
          end
        end
        CLEAR: begin
          if (cnt_q == CLEAR_LAST) begin
            aclr_q   <= 1'b0;
            enable_q <= 1'b1;
            cnt_q    <= 8'h00;
            if (FLUSH_SAMPLES == 0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FLUSH;
            end
          end else begin
            cnt_q <= sat_inc8(cnt_q);
          end
        end
        FLUSH: begin
          if (ddc_strobe_in) begin
            if (cnt_q == FLUSH_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              cnt_q   <= 8'h00;
            end else begin
              cnt_q <= sat_inc8(cnt_q);
            end
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddc_retune_sequencer.sv
// Directed self-checking bench for ddc_retune_sequencer with default parameters
// (addresses 0/1, four aclr cycles, sixteen flushed strobes).
module tb_ddc_retune_sequencer;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_freq;
  logic [12:0] req_decim;
  logic [1:0]  req_mask;
  logic [3:0]  req_cfgflags;
  logic        busy;
  logic        done;
  logic        ddc_enable;
  logic        ddc_aclr;
  logic [3:0]  ddc_cfgflags;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_data;
  logic        bus_we;
  logic        bus_strobe;
  logic        ddc_strobe_in;
  logic        iq_valid;

  int checks = 0;
  int errors = 0;

  ddc_retune_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_freq      (req_freq),
    .req_decim     (req_decim),
    .req_mask      (req_mask),
    .req_cfgflags  (req_cfgflags),
    .busy          (busy),
    .done          (done),
    .ddc_enable    (ddc_enable),
    .ddc_aclr      (ddc_aclr),
    .ddc_cfgflags  (ddc_cfgflags),
    .bus_addr      (bus_addr),
    .bus_data      (bus_data),
    .bus_we        (bus_we),
    .bus_strobe    (bus_strobe),
    .ddc_strobe_in (ddc_strobe_in),
    .iq_valid      (iq_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic applyStimulus(input logic [31:0] f, input logic [12:0] d,
                               input logic [1:0] m, input logic [3:0] c);
    bit accepted = 0;
    req_freq = f; req_decim = d; req_mask = m; req_cfgflags = c;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && !accepted; i++) begin
      if (req_ready) begin
        @(posedge clock);
        accepted = 1;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    if (!accepted) checkOutput("acceptTimeout", 0, 1);
  endtask

  // Starts on the setup cycle of a byte, ends on the next slot's first cycle.
  task automatic checkByteSlot(input logic [7:0] a, input logic [7:0] d);
    checkOutput("setupWe", bus_we, 1);
    checkOutput("setupStrobe", bus_strobe, 0);
    checkOutput("setupAddr", bus_addr, a);
    checkOutput("setupData", bus_data, d);
    @(negedge clock);
    checkOutput("strobeWe", bus_we, 1);
    checkOutput("strobeStrobe", bus_strobe, 1);
    checkOutput("strobeAddr", bus_addr, a);
    checkOutput("strobeData", bus_data, d);
    @(negedge clock);
    checkOutput("holdWe", bus_we, 1);
    checkOutput("holdStrobe", bus_strobe, 0);
    checkOutput("holdAddr", bus_addr, a);
    @(negedge clock);
  endtask

  // Starts on the first CLEAR cycle, ends on the first FLUSH cycle.
  task automatic checkClear(input logic [3:0] cfg);
    for (int i = 0; i < 4; i++) begin
      checkOutput("clearAclr", ddc_aclr, 1);
      checkOutput("clearEnable", ddc_enable, 0);
      checkOutput("clearCfg", ddc_cfgflags, cfg);
      checkOutput("clearBusQuiet", {bus_we, bus_strobe, bus_addr, bus_data}, 0);
      checkOutput("clearBusy", busy, 1);
      @(negedge clock);
    end
    checkOutput("flushAclr", ddc_aclr, 0);
    checkOutput("flushEnable", ddc_enable, 1);
  endtask

  // One strobe every other cycle; ends on the gap cycle after the last pulse.
  task automatic runFlush(input int n);
    for (int k = 1; k <= n; k++) begin
      ddc_strobe_in = 1'b1;
      #1;
      checkOutput($sformatf("iqPulse%0d", k), iq_valid, (k > 16) ? 1 : 0);
      checkOutput($sformatf("readyPulse%0d", k), req_ready, (k > 16) ? 1 : 0);
      @(negedge clock);
      ddc_strobe_in = 1'b0;
      #1;
      checkOutput($sformatf("doneGap%0d", k), done, (k == 16) ? 1 : 0);
      checkOutput($sformatf("readyGap%0d", k), req_ready, (k > 16) ? 1 : 0);
      if (k < n) @(negedge clock);
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_freq = '0; req_decim = '0;
    req_mask = '0; req_cfgflags = '0; ddc_strobe_in = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rstReady", req_ready, 1);
    checkOutput("rstEnable", ddc_enable, 1);
    checkOutput("rstBusyDone", {busy, done}, 0);
    checkOutput("rstAclrCfg", {ddc_aclr, ddc_cfgflags}, 0);
    checkOutput("rstBus", {bus_we, bus_strobe, bus_addr, bus_data}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    ddc_strobe_in = 1'b1;
    #1 checkOutput("idlePassHigh", iq_valid, 1);
    ddc_strobe_in = 1'b0;
    #1 checkOutput("idlePassLow", iq_valid, 0);
    @(negedge clock);

    // Full write of both registers, then 20 strobes through the flush window
    applyStimulus(32'h12345678, 13'h1F40, 2'b11, 4'h0);
    checkOutput("busyA", busy, 1);
    checkByteSlot(8'd0, 8'h78);
    checkByteSlot(8'd0, 8'h56);
    checkByteSlot(8'd0, 8'h34);
    checkByteSlot(8'd0, 8'h12);
    checkByteSlot(8'd1, 8'h40);
    checkByteSlot(8'd1, 8'h1F);
    checkClear(4'h0);
    runFlush(20);
    @(negedge clock);
    checkOutput("idleBusyA", busy, 0);

    // Decimation only, with the next request held pending through the flush
    applyStimulus(32'hFFFFFFFF, 13'h0005, 2'b10, 4'h3);
    checkByteSlot(8'd1, 8'h05);
    checkByteSlot(8'd1, 8'h00);
    checkClear(4'h3);
    req_freq = 32'hDEADBEEF; req_decim = 13'h0AAA; req_mask = 2'b00; req_cfgflags = 4'hA;
    req_valid = 1'b1;
    runFlush(16);
    @(negedge clock);
    checkOutput("heldReady", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;

    // Mask 00: straight into CLEAR with the new bypass flags
    checkOutput("noWriteReady", req_ready, 0);
    checkClear(4'hA);
    runFlush(16);
    @(negedge clock);
    checkOutput("idleBusyC", {busy, done}, 0);

    // Reset in the middle of the third frequency byte
    applyStimulus(32'hAABBCCDD, 13'h0123, 2'b01, 4'h5);
    checkByteSlot(8'd0, 8'hDD);
    checkByteSlot(8'd0, 8'hCC);
    checkOutput("byte2Data", bus_data, 8'hBB);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("asyncBus", {bus_we, bus_strobe, bus_addr, bus_data}, 0);
    checkOutput("asyncReady", req_ready, 1);
    checkOutput("asyncEnable", ddc_enable, 1);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncCfg", ddc_cfgflags, 4'h0);
    #1 reset_n = 1'b1;
    @(negedge clock);
    applyStimulus(32'hAABBCCDD, 13'h0123, 2'b01, 4'h5);
    checkByteSlot(8'd0, 8'hDD);
    checkByteSlot(8'd0, 8'hCC);
    checkByteSlot(8'd0, 8'hBB);
    checkByteSlot(8'd0, 8'hAA);
    checkClear(4'h5);
    runFlush(16);
    @(negedge clock);
    checkOutput("idleBusyD", {busy, done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddc_retune_sequencer.md
Name: ddc_retune_sequencer

Overview:
- Sequences a retune of the 12-bit DDC chain (CORDIC/CIC/halfband) in a defined order: programs the IF frequency word and the decimation rate over the rbus, applies the DDC bypass flags, and pulses aclr.
- Then discards the first FLUSH_SAMPLES output strobes so that no stale or transient samples reach downstream.
- Sits between the host control logic and the DDC instance, and acts as the rbus write master for the two DDC configuration registers.

Parameters:
- IF_FREQ_ADDR, 0: rbus address of the 32-bit IF phase-increment register.
- DECIM_RATE_ADDR, 1: rbus address of the decimation-rate register (13 significant bits).
- CLEAR_CYCLES, 4: clock cycles ddc_aclr is held high; valid range 1..255.
- FLUSH_SAMPLES, 16: DDC output strobes discarded after aclr is released; valid range 0..255.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  retune request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_freq  in  32  IF phase increment.
- req_decim  in  13  decimation rate.
- req_mask  in  2  bit0 = write freq, bit1 = write decim.
- req_cfgflags  in  4  DDC bypass flags to apply.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when the sequence completes.
- ddc_enable  out  1  DDC enable.
- ddc_aclr  out  1  DDC state clear.
- ddc_cfgflags  out  4  registered DDC bypass flags.
- bus_addr  out  8  rbus address.
- bus_data  out  8  rbus write byte.
- bus_we  out  1  rbus write enable.
- bus_strobe  out  1  rbus data strobe.
- ddc_strobe_in  in  1  DDC dstrobe_out.
- iq_valid  out  1  ddc_strobe_in gated by flush blanking.

Behaviour:
- Reset (async, reset_n low) drives every output to 0, except req_ready and ddc_enable, which reset to 1. State is IDLE; the shadow registers clear to 0.
- IDLE:
  - req_ready = 1 and busy = 0.
  - On accept, capture freq/decim/mask/cfgflags into the shadow registers and set busy the next cycle.
  - If mask = 2'b00, go to CLEAR. Otherwise go to WR_SETUP with the byte pointer at the first byte selected by the mask.
- Byte list, in order:
  - freq bytes 0..3, LSB first, at IF_FREQ_ADDR (when mask[0] is set).
  - decim bytes 0..1, LSB first, at DECIM_RATE_ADDR (when mask[1] is set). Byte 1 is {3'b000, decim[12:8]}.
- Per byte, three cycles:
  - WR_SETUP: bus_addr, bus_data and bus_we = 1 are driven.
  - WR_STROBE: the same values plus bus_strobe = 1.
  - WR_HOLD: bus_we = 1, bus_strobe = 0.
  - Advance to the next byte. After the last byte, go to CLEAR.
- Write timing: 4 freq bytes take 12 cycles; the full write of 6 bytes takes 18 cycles.
- Outside the WR_* states, bus_we, bus_strobe, bus_addr and bus_data are all 0.
- CLEAR:
  - On entry, ddc_cfgflags is loaded from the shadow register.
  - ddc_aclr = 1 and ddc_enable = 0 for exactly CLEAR_CYCLES cycles.
  - Then go to FLUSH with ddc_enable = 1.
- FLUSH:
  - Count ddc_strobe_in pulses; iq_valid is forced to 0.
  - After FLUSH_SAMPLES strobes have been counted, go to DONE. If FLUSH_SAMPLES = 0, go to DONE immediately.
- DONE: done = 1 for one cycle, then IDLE.
- Outside FLUSH: iq_valid = ddc_strobe_in (combinational pass-through, zero latency). This includes IDLE and the strobe in the same cycle the state returns to IDLE.
- req_valid while busy: ignored and not queued. The requester must hold req_valid until req_ready.
- Request inputs changing mid-sequence: no effect, because only the shadow registers are used.
- Reset asserted mid-sequence: immediate return to the reset values. A partially written register is the host's concern; a new request rewrites all bytes selected by the mask.
- Counters:
  - 3-bit byte pointer.
  - 8-bit clear/flush counter. It saturates and never wraps.

Decomposition:
- Shared package ddc_ctrl_pkg holds:
  - the state enum (IDLE, WR_SETUP, WR_STROBE, WR_HOLD, CLEAR, FLUSH, DONE);
  - mask bit indices MASK_FREQ = 0, MASK_DECIM = 1;
  - byte counts FREQ_BYTES = 4, DECIM_BYTES = 2.
- One sub-module, rbus_byte_writer: a three-phase single-byte write engine with start/addr/data inputs and a ready output. The FSM instantiates it once and iterates over the byte list.

Test Plan:
- Reset, then a request with freq = 32'h12345678, decim = 13'h1F40, mask = 2'b11, cfgflags = 4'h0:
  - bytes 78, 56, 34, 12 at addr 0, then 40, 1F at addr 1;
  - exactly one bus_strobe per byte, on the 2nd cycle of each 3-cycle slot;
  - followed by 4 cycles of ddc_aclr = 1.
- mask = 2'b10, decim = 13'h0005: only bytes 05, 00 are written at addr 1, and no write occurs at addr 0.
- After CLEAR, drive 20 ddc_strobe_in pulses with FLUSH_SAMPLES = 16: iq_valid is low for the first 16 pulses and high for pulses 17–20; done pulses once after pulse 16.
- Hold req_valid during FLUSH: req_ready stays 0, and the request is accepted in the first IDLE cycle after done.
- mask = 2'b00, cfgflags = 4'hA: no bus activity; ddc_cfgflags = 4'hA when ddc_aclr rises.
- Assert reset_n low during the 3rd freq byte: outputs return to reset values asynchronously; the next request restarts from byte 0.
